// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: decoupled instruction-fetch front end for the RV32 pipeline.
// Issues sequential word fetches to a variable-latency instruction memory and
// buffers returned {pc, instr} pairs in a DEPTH-entry queue for decode. A
// redirect from EX flushes the queue and discards in-flight responses.
//
// Optional feature macro: FETCH_BYPASS_EN
//   Defined   : a response arriving while the queue is empty (no discard, no
//               redirect) is presented to decode in the same cycle.
//   Undefined : fixed one-cycle response-to-decode latency.
//
// Ports:
//   clk, reset        core clock (rising edge), asynchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word-aligned addr)
//   imem_rsp_*        in-order response channel (valid, instruction word)
//   redirect_*        EX-stage flush/restart with new PC (bits [1:0] ignored)
//   if_*              decode-side head entry (valid/ready, pc, instr)
//   inflight          outstanding request count (debug)
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [XLEN-1:0]            if_pc,
    output logic [ILEN-1:0]            if_instr,
    output logic [$clog2(DEPTH):0]     inflight
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Architectural state
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    // Per-cycle control
    logic            req_fire;
    logic            rsp_keep;
    logic            queue_empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   outstanding_next;
    logic [XLEN-1:0] redirect_aligned;
    logic            redirect_lsb_unused;

    assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Credit: in-flight requests plus buffered entries never exceed DEPTH
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response survives only when nothing stale is pending and no flush is underway
    assign rsp_keep    = imem_rsp_valid && (discard == '0) && !redirect_valid && !reset;
    assign queue_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
    // Popping the last entry already occupies the decode port, so bypass needs an empty queue
    assign bypass = rsp_keep && queue_empty;
`else
    assign bypass = 1'b0;
`endif

    assign if_valid = !queue_empty || bypass;
    assign pop      = !queue_empty && if_ready && !redirect_valid;
    // A bypassed word consumed by decode never enters the queue
    assign push     = rsp_keep && !(bypass && if_ready);

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign inflight         = outstanding;

    // Decode-side view: head entry, bypassed response, or zero when idle
    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (!queue_empty) begin
            if_pc    = pc_mem[rd_ptr];
            if_instr = instr_mem[rd_ptr];
        end else if (bypass) begin
            if_pc    = rsp_pc;
            if_instr = imem_rsp_data;
        end
    end

    // Fetch/response PC counters, credit and discard bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                // Everything still in flight after this edge belongs to the old path
                discard  <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    // Queue occupancy and pointers; redirect empties the queue and overrides pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(push) - CW'(pop);
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    // Memory must never return more words than were requested
    a_rsp_has_request: assert property (
        @(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0)
    );
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit. The reference model tracks requests
// as (address, due cycle, epoch) records and the decode queue as (pc, instr)
// pairs; a redirect bumps the epoch so any older response is dropped.
module tb_fetch_queue_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic [CW-1:0]   inflight;

    fetch_queue_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    int unsigned epoch;
    int unsigned cyc;
    int unsigned last_due;
    int unsigned n_tests;
    int unsigned n_fail;

    int unsigned p_ready;
    int unsigned p_if_ready;
    int unsigned p_redir;
    int unsigned max_lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] pick_redirect();
        case ($urandom_range(4))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0202;
            2:       return 32'hFFFF_FFF8;
            3:       return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_if_valid",  32'(if_valid),       32'd0);
        check_eq("rst_inflight",  32'(inflight),       32'd0);
        check_eq("rst_if_pc",     if_pc,               32'd0);
        check_eq("rst_if_instr",  if_instr,            32'd0);
        pend.delete();
        mq.delete();
        m_fetch_pc = 32'h0000_0000;
        epoch++;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        last_due = cyc;
    endtask

    task automatic run_cycles(input int n);
        logic   m_req_valid;
        logic   keep;
        logic   byp;
        logic   fire;
        logic   pop;
        logic   exp_valid;
        ent_t   shown;
        ent_t   rsp_ent;
        req_t   r;
        int unsigned lat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(99) < p_ready);
            if_ready       = ($urandom_range(99) < p_if_ready);
            redirect_valid = ($urandom_range(999) < p_redir);
            redirect_pc    = pick_redirect();
            if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(3) != 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            #1;

            m_req_valid = !redirect_valid && (pend.size() + mq.size() < DEPTH);
            keep        = imem_rsp_valid && !redirect_valid && (pend[0].epoch == epoch);
            rsp_ent.pc    = imem_rsp_valid ? pend[0].addr : 32'd0;
            rsp_ent.instr = imem_rsp_data;
            exp_valid   = (mq.size() != 0);
            shown       = exp_valid ? mq[0] : rsp_ent;
            byp         = 1'b0;
`ifdef FETCH_BYPASS_EN
            if (mq.size() == 0 && keep) begin
                byp       = 1'b1;
                exp_valid = 1'b1;
            end
`endif
            check_eq("req_valid", 32'(imem_req_valid), 32'(m_req_valid));
            check_eq("inflight",  32'(inflight),       32'(pend.size()));
            check_eq("if_valid",  32'(if_valid),       32'(exp_valid));
            if (m_req_valid) check_eq("req_addr", imem_req_addr, m_fetch_pc);
            if (exp_valid) begin
                check_eq("if_pc",    if_pc,    shown.pc);
                check_eq("if_instr", if_instr, shown.instr);
            end

            fire = m_req_valid && imem_req_ready;
            pop  = (mq.size() != 0) && if_ready && !redirect_valid;
            if (pop) void'(mq.pop_front());
            if (imem_rsp_valid) begin
                void'(pend.pop_front());
                if (keep && !(byp && if_ready)) mq.push_back(rsp_ent);
            end
            if (fire) begin
                lat      = $urandom_range(max_lat, 1);
                r.addr   = m_fetch_pc;
                r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                r.epoch  = epoch;
                last_due = r.due;
                pend.push_back(r);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                mq.delete();
                epoch++;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end
            cyc++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        epoch   = 0;
        last_due = 0;
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        do_reset();

        // Streaming with 1-cycle memory and free-running decode
        p_ready = 100; p_if_ready = 100; p_redir = 0; max_lat = 1;
        run_cycles(40);

        // Decode stall fills the queue, then drains in order
        p_if_ready = 0;
        run_cycles(20);
        p_if_ready = 100;
        run_cycles(20);

        // Longer latency with occasional redirects
        max_lat = 3; p_redir = 50;
        run_cycles(400);

        // Heavy mix: back-pressure on both sides and frequent redirects
        p_ready = 60; p_if_ready = 50; p_redir = 150; max_lat = 4;
        run_cycles(1500);

        // Reset in the middle of traffic
        do_reset();
        p_ready = 80; p_if_ready = 70; p_redir = 80; max_lat = 3;
        run_cycles(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
